// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module   : fifo_rd_stream
// Purpose  : Drains a 1-cycle-latency synchronous FIFO into a valid/ready
//            stream through a 2-entry skid buffer, counting delivered words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

  logic                  pop;
  logic                  push;
  logic [2:0]            credit;
  logic                  rd_en;

  always_comb begin
    pop  = m_valid_q && m_ready;
    push = inflight_q;

    // Words held plus words in flight, net of the one leaving this cycle.
    // The encoding of occ_q equals its word count; pop implies occ >= 1.
    credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en  = !rst && !fifo_empty && !flush && (credit < 3'd2);

    occ_d      = occ_q;
    m_data_d   = m_data_q;
    skid_d     = skid_q;
    inflight_d = rd_en;
    word_cnt_d = word_cnt_q;

    case (occ_q)
      EMPTY: begin
        if (push) begin
          m_data_d = fifo_data;
          occ_d    = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          m_data_d = fifo_data;
        end else if (push) begin
          skid_d = fifo_data;
          occ_d  = TWO;
        end else if (pop) begin
          occ_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          m_data_d = skid_q;
          occ_d    = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase

    if (pop) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end

    // A flushed in-flight word is simply never captured.
    if (flush) begin
      occ_d      = EMPTY;
      inflight_d = 1'b0;
    end

    m_valid_d = (occ_d != EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      skid_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      skid_q     <= skid_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign word_cnt   = word_cnt_q;
  assign busy       = (occ_q != EMPTY) || inflight_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// Module   : tb_fifo_rd_stream
// Purpose  : Directed self-checking bench for fifo_rd_stream with a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic        flush;
  logic [15:0] word_cnt;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int reads = 0;
  int viol  = 0;
  logic [15:0] exp_cnt = 16'd0;

  logic [7:0] fifo_q[$];
  logic [7:0] received[$];

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_f = 1'b0;
  logic [7:0] prev_d = 8'h00;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .flush      (flush),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, empty flag updated with the pointers.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Stream monitor and protocol invariants.
  always @(posedge clk) begin
    logic [1:0] occ_v;
    int         credit;
    if (!rst) begin
      occ_v  = dut.occ_q;
      credit = int'(occ_v) + int'(dut.inflight_q) - int'(m_valid && m_ready);
      if (m_valid && m_ready) received.push_back(m_data);
      if (fifo_rd_en) reads++;
      if (occ_v == 2'd2 && dut.inflight_q) viol++;
      if (fifo_rd_en && credit >= 2) viol++;
      if (prev_v && !prev_r && !prev_f && (!m_valid || m_data !== prev_d)) viol++;
      prev_v = m_valid;
      prev_r = m_ready;
      prev_f = flush;
      prev_d = m_data;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (received.size() >= n) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00; m_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    tests++;
    if ({m_valid, m_data, word_cnt, busy, fifo_rd_en} !== 27'd0) begin
      fails++;
      $display("FAIL reset: got v=%b d=%h cnt=%0d busy=%b rd=%b expected all zero",
               m_valid, m_data, word_cnt, busy, fifo_rd_en);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    reads = 0; received.delete(); m_ready = 1'b1;
    push_word(8'hA5);
    #1;
    tests++;
    if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL single_rd_now: got %b expected 1", fifo_rd_en); end
    tick();
    tests++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL single_n1: got rd=%b v=%b busy=%b expected 0 0 1", fifo_rd_en, m_valid, busy);
    end
    tick();
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      fails++; $display("FAIL single_n2: got v=%b d=%h expected 1 a5", m_valid, m_data);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    tests++;
    if (m_valid !== 1'b0 || word_cnt !== exp_cnt || reads != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL single_done: got v=%b cnt=%0d reads=%0d busy=%b expected 0 %0d 1 0",
                        m_valid, word_cnt, reads, busy, exp_cnt);
    end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        fails++; $display("FAIL stream_word%0d: got v=%b d=%h expected 1 %h", i, m_valid, m_data, 8'(i));
      end
      tick();
    end
    exp_cnt = exp_cnt + 16'd16;
    tests++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || word_cnt !== exp_cnt) begin
      fails++; $display("FAIL stream_end: got v=%b rd=%b cnt=%0d expected 0 0 %0d",
                        m_valid, fifo_rd_en, word_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_pressure();
    m_ready = 1'b0; reads = 0;
    for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
    repeat (5) tick();
    tests++;
    if (reads != 2 || m_valid !== 1'b1 || m_data !== 8'h40 || fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL bp_hold: got reads=%0d v=%b d=%h rd=%b busy=%b expected 2 1 40 0 1",
                        reads, m_valid, m_data, fifo_rd_en, busy);
    end
    received.delete(); m_ready = 1'b1;
    wait_rx(4, 20);
    tick();
    tests++;
    if (received.size() != 4) begin
      fails++; $display("FAIL bp_count: got %0d words expected 4", received.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (received[i] !== 8'h40 + 8'(i)) begin
          fails++; $display("FAIL bp_order%0d: got %h expected %h", i, received[i], 8'h40 + 8'(i));
        end
      end
    end
    exp_cnt = exp_cnt + 16'd4;
  endtask

  task automatic test_toggle_ready();
    received.delete(); m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h50 + 8'(i));
    for (int k = 0; k < 80 && received.size() < 8; k++) begin
      m_ready = ~m_ready;
      tick();
    end
    m_ready = 1'b1;
    repeat (3) tick();
    tests++;
    if (received.size() != 8) begin
      fails++; $display("FAIL toggle_count: got %0d words expected 8", received.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (received[i] !== 8'h50 + 8'(i)) begin
          fails++; $display("FAIL toggle_order%0d: got %h expected %h", i, received[i], 8'h50 + 8'(i));
        end
      end
    end
    exp_cnt = exp_cnt + 16'd8;
    tests++;
    if (word_cnt !== exp_cnt) begin
      fails++; $display("FAIL toggle_cnt: got %0d expected %0d", word_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'h60 + 8'(i));
    repeat (5) tick();
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h60 || dut.occ_q !== 2'd2) begin
      fails++; $display("FAIL flush_pre: got v=%b d=%h occ=%0d expected 1 60 2", m_valid, m_data, dut.occ_q);
    end
    // One pop from TWO issues the read of 0x62; then flush drops 0x61 and 0x62.
    m_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    m_ready = 1'b0; flush = 1'b1;
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL flush_rd: got %b expected 0", fifo_rd_en); end
    tick();
    flush = 1'b0;
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== exp_cnt) begin
      fails++; $display("FAIL flush_post: got v=%b busy=%b cnt=%0d expected 0 0 %0d",
                        m_valid, busy, word_cnt, exp_cnt);
    end
    received.delete(); m_ready = 1'b1;
    wait_rx(3, 20);
    tick();
    tests++;
    if (received.size() != 3) begin
      fails++; $display("FAIL flush_count: got %0d words expected 3", received.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (received[i] !== 8'h63 + 8'(i)) begin
          fails++; $display("FAIL flush_order%0d: got %h expected %h", i, received[i], 8'h63 + 8'(i));
        end
      end
    end
    exp_cnt = exp_cnt + 16'd3;
  endtask

  task automatic test_async_reset();
    logic [7:0] head;
    int         n;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'h70 + 8'(i));
    repeat (4) tick();
    #2;
    rst = 1'b1;
    head = fifo_q[0];
    n = fifo_q.size();
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || word_cnt !== 16'd0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL async_rst: got v=%b d=%h cnt=%0d busy=%b rd=%b expected all zero",
                        m_valid, m_data, word_cnt, busy, fifo_rd_en);
    end
    tests++;
    if (head !== 8'h74 || n != 4) begin
      fails++; $display("FAIL async_head: got head=%h left=%0d expected 74 4", head, n);
    end
    exp_cnt = 16'd0;
    tick();
    received.delete();
    rst = 1'b0;
    wait_rx(n, 20);
    tick();
    tests++;
    if (received.size() != n) begin
      fails++; $display("FAIL async_count: got %0d words expected %0d", received.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        tests++;
        if (received[i] !== head + 8'(i)) begin
          fails++; $display("FAIL async_order%0d: got %h expected %h", i, received[i], head + 8'(i));
        end
      end
    end
    exp_cnt = 16'(n);
    tests++;
    if (word_cnt !== exp_cnt) begin
      fails++; $display("FAIL async_cnt: got %0d expected %0d", word_cnt, exp_cnt);
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (viol != 0) begin
      fails++; $display("FAIL invariants: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_toggle_ready();
    test_flush();
    test_async_reset();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
